// File: rtl/ritc_phase_scan_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// ritc_phase_scan_accumulator_pkg
// Shared definitions for the phase-scan accumulator: FSM state encoding,
// the bit-select map of the 40 scannable phase-scanner bits and the default
// maximum log2 sample count.
// ---------------------------------------------------------------------------
package ritc_phase_scan_accumulator_pkg;

    localparam int MAX_LOG2   = 12;
    localparam int SCAN_NBITS = 40;
    localparam int SEL_W      = 6;

    // sel_i ranges: CLK_Q[2:0], CH0_Q[11:0], CH1_Q[11:0], CH2_Q[11:0], VCDL_Q
    localparam int CLK_BASE = 0;
    localparam int CH0_BASE = 3;
    localparam int CH1_BASE = 15;
    localparam int CH2_BASE = 27;
    localparam int VCDL_IDX = 39;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SETTLE,
        ST_ACCUM,
        ST_DONE
    } scan_state_e;

    // Limit the requested log2 sample count to what the accumulator can hold.
    function automatic logic [3:0] clamp_log2(input logic [3:0] n, input logic [3:0] max_n);
        return (n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/ritc_scan_bit_mux.sv
// ---------------------------------------------------------------------------
// ritc_scan_bit_mux
// Combinational selector: picks one of the 40 resynced phase-scanner bits.
// Ports:
//   i_sel      bit index (0-39); out-of-range indices yield 0
//   i_clk_q    CLK_Q[2:0]
//   i_ch0_q    CH0_Q[11:0]
//   i_ch1_q    CH1_Q[11:0]
//   i_ch2_q    CH2_Q[11:0]
//   i_vcdl_q   VCDL_Q
//   o_bit      selected bit
// ---------------------------------------------------------------------------
module ritc_scan_bit_mux
    import ritc_phase_scan_accumulator_pkg::*;
(
    input  logic [SEL_W-1:0] i_sel,
    input  logic [2:0]       i_clk_q,
    input  logic [11:0]      i_ch0_q,
    input  logic [11:0]      i_ch1_q,
    input  logic [11:0]      i_ch2_q,
    input  logic             i_vcdl_q,
    output logic             o_bit
);

    localparam logic [SEL_W-1:0] NB_SEL = SEL_W'(SCAN_NBITS);

    logic [SCAN_NBITS-1:0] w_bits;

    always_comb begin
        w_bits                  = '0;
        w_bits[CLK_BASE +: 3]   = i_clk_q;
        w_bits[CH0_BASE +: 12]  = i_ch0_q;
        w_bits[CH1_BASE +: 12]  = i_ch1_q;
        w_bits[CH2_BASE +: 12]  = i_ch2_q;
        w_bits[VCDL_IDX]        = i_vcdl_q;
    end

    always_comb begin
        o_bit = 1'b0;
        if (i_sel < NB_SEL)
            o_bit = w_bits[i_sel];
    end

endmodule

// File: rtl/ritc_phase_scan_accumulator.sv
// ---------------------------------------------------------------------------
// ritc_phase_scan_accumulator
// On a start request, pulses the phase scanner, waits a programmable settle
// time, then counts how many of 2^n consecutive samples of one selected
// scanner bit are '1'.
// Ports:
//   user_clk_i / user_rst_n_i   clock, async active-low reset
//   start_i, abort_i            scan request / cancel
//   sel_i, nsamp_log2_i,        bit select, log2 sample count (clamped),
//   settle_i                    settle cycles (all latched at start)
//   CLK_Q_i..VCDL_Q_i           resynced scanner samples
//   scan_o                      one-cycle pulse to the scanner
//   busy_o                      scan in progress (scan_o cycle .. done_o cycle)
//   done_o, count_o             completion pulse and '1'-sample count
//   sel_err_o                   pulse when a start carried an invalid sel_i
// ---------------------------------------------------------------------------
module ritc_phase_scan_accumulator #(
    parameter int MAX_LOG2 = 12,
    parameter int NBITS    = 40
) (
    input  logic              user_clk_i,
    input  logic              user_rst_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [5:0]        sel_i,
    input  logic [3:0]        nsamp_log2_i,
    input  logic [7:0]        settle_i,
    input  logic [2:0]        CLK_Q_i,
    input  logic [11:0]       CH0_Q_i,
    input  logic [11:0]       CH1_Q_i,
    input  logic [11:0]       CH2_Q_i,
    input  logic              VCDL_Q_i,
    output logic              scan_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [MAX_LOG2:0] count_o,
    output logic              sel_err_o
);

    import ritc_phase_scan_accumulator_pkg::*;

    localparam int AW = MAX_LOG2 + 1;
    // Counter serves both the settle wait (8-bit) and the sample window.
    localparam int CW = (MAX_LOG2 > 8) ? MAX_LOG2 : 8;
    localparam logic [5:0] NBITS_SEL = 6'(NBITS);
    localparam logic [3:0] MAXL      = 4'(MAX_LOG2);

    scan_state_e     r_state, w_state_nxt;
    logic [5:0]      r_sel;
    logic [3:0]      r_nlog2;
    logic [7:0]      r_settle;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   r_count;
    logic            r_sel_err;

    logic            w_bit;
    logic            w_start_ok;
    logic            w_start_bad;
    logic [CW-1:0]   w_accum_len;
    logic [AW-1:0]   w_acc_sum;

    // The mux reads the latched select but the live samples.
    ritc_scan_bit_mux u_bit_mux (
        .i_sel    (r_sel),
        .i_clk_q  (CLK_Q_i),
        .i_ch0_q  (CH0_Q_i),
        .i_ch1_q  (CH1_Q_i),
        .i_ch2_q  (CH2_Q_i),
        .i_vcdl_q (VCDL_Q_i),
        .o_bit    (w_bit)
    );

    assign w_start_ok  = (r_state == ST_IDLE) && start_i && (sel_i < NBITS_SEL);
    assign w_start_bad = (r_state == ST_IDLE) && start_i && !(sel_i < NBITS_SEL);
    // Count loaded as (cycles - 1) so the exit condition is r_cnt == 0.
    assign w_accum_len = CW'((32'd1 << r_nlog2) - 32'd1);
    assign w_acc_sum   = r_acc + AW'(w_bit);

    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_start_ok) w_state_nxt = ST_REQ;
            ST_REQ:    w_state_nxt = (r_settle == '0) ? ST_ACCUM : ST_SETTLE;
            ST_SETTLE: if (r_cnt == '0) w_state_nxt = ST_ACCUM;
            ST_ACCUM:  if (r_cnt == '0) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        // Abort overrides every transition; start+abort in IDLE still starts.
        if (abort_i && (r_state != ST_IDLE))
            w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            r_sel     <= '0;
            r_nlog2   <= '0;
            r_settle  <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_start_bad;

            if (w_start_ok) begin
                r_sel    <= sel_i;
                r_nlog2  <= clamp_log2(nsamp_log2_i, MAXL);
                r_settle <= settle_i;
            end

            if ((r_state == ST_REQ) && (w_state_nxt == ST_SETTLE)) begin
                r_cnt <= CW'(r_settle) - CW'(1);
            end else if ((r_state != ST_ACCUM) && (w_state_nxt == ST_ACCUM)) begin
                r_cnt <= w_accum_len;
                r_acc <= '0;
            end else if ((r_state == ST_SETTLE) || (r_state == ST_ACCUM)) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (r_state == ST_ACCUM)
                r_acc <= w_acc_sum;

            // Capture includes the final sample so count_o is valid during done_o.
            if ((r_state == ST_ACCUM) && (w_state_nxt == ST_DONE))
                r_count <= w_acc_sum;
        end
    end

    assign scan_o    = (r_state == ST_REQ);
    assign busy_o    = (r_state != ST_IDLE);
    assign done_o    = (r_state == ST_DONE);
    assign count_o   = r_count;
    assign sel_err_o = r_sel_err;

endmodule

// File: tb/tb_ritc_phase_scan_accumulator.sv
module tb_ritc_phase_scan_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [5:0]  sel = '0;
    logic [3:0]  nl = '0;
    logic [7:0]  st = '0;
    logic [2:0]  clkq = '0;
    logic [11:0] ch0 = '0, ch1 = '0, ch2 = '0;
    logic        vcdl = 1'b0;
    logic        scan, busy, done, serr;
    logic [12:0] cnt;

    ritc_phase_scan_accumulator dut (
        .user_clk_i   (clk),
        .user_rst_n_i (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .sel_i        (sel),
        .nsamp_log2_i (nl),
        .settle_i     (st),
        .CLK_Q_i      (clkq),
        .CH0_Q_i      (ch0),
        .CH1_Q_i      (ch1),
        .CH2_Q_i      (ch2),
        .VCDL_Q_i     (vcdl),
        .scan_o       (scan),
        .busy_o       (busy),
        .done_o       (done),
        .count_o      (cnt),
        .sel_err_o    (serr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cnt;
        int blen;
    } done_t;

    int    scan_q[$];
    int    err_q[$];
    done_t done_q[$];

    int nchk = 0;
    int nerr = 0;
    int last_count = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s: unexpected pulse at cycle %0d", nm, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    int busy_run = 0;
    bit post_done = 1'b0;
    always @(negedge clk) begin
        done_t d;
        if (busy) busy_run++;
        else      busy_run = 0;
        if (post_done) begin
            chk("busy_after_done", int'(busy), 0);
            post_done = 1'b0;
        end
        if (scan) begin
            if (scan_q.size() == 0) unexp("scan");
            else chk("scan_cycle", cyc, scan_q.pop_front());
        end
        if (done) begin
            if (done_q.size() == 0) unexp("done");
            else begin
                d = done_q.pop_front();
                chk("done_cycle", cyc, d.cyc);
                chk("count", int'(cnt), d.cnt);
                chk("busy_len", busy_run, d.blen);
                post_done = 1'b1;
            end
        end
        if (serr) begin
            if (err_q.size() == 0) unexp("sel_err");
            else chk("sel_err_cycle", cyc, err_q.pop_front());
        end
    end

    task automatic drive_vec(input logic [39:0] v);
        clkq = v[2:0];
        ch0  = v[14:3];
        ch1  = v[26:15];
        ch2  = v[38:27];
        vcdl = v[39];
    endtask

    // mode 0 random, 1 all ones, 2 toggling each cycle, 3 all zeros
    function automatic logic [39:0] gen(input int mode, input int i);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case (mode)
            1:       return '1;
            2:       return ((i & 1) != 0) ? '1 : '0;
            3:       return '0;
            default: return r[39:0];
        endcase
    endfunction

    // Called at posedge+#1; that cycle carries the start request.
    task automatic run_scan(input int sel_v, input int nl_v, input int st_v, input int mode,
                            input int abort_at, input int dup_at, input int rst_at);
        logic [39:0] vec[$];
        int neff, len, s, exp_cnt;
        neff = (nl_v > 12) ? 12 : nl_v;
        len  = 2 + st_v + (1 << neff);
        s    = cyc;
        exp_cnt = 0;

        if (sel_v >= 40) begin
            err_q.push_back(s + 1);
            sel = 6'(sel_v); nl = 4'(nl_v); st = 8'(st_v); start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("selerr_busy", int'(busy), 0);
                chk("selerr_count", int'(cnt), last_count);
            end
            @(posedge clk); #1;
            return;
        end

        for (int i = 0; i <= len; i++) vec.push_back(gen(mode, i));
        // Samples are taken in the 2^n cycles following REQ and the settle wait.
        for (int j = 0; j < (1 << neff); j++) exp_cnt += int'(vec[2 + st_v + j][sel_v]);

        scan_q.push_back(s + 1);
        if (abort_at < 0 && rst_at < 0)
            done_q.push_back('{s + len, exp_cnt, len});

        for (int i = 0; i <= len; i++) begin
            drive_vec(vec[i]);
            start = (i == 0) || (i == dup_at);
            if (i == 0) begin
                sel = 6'(sel_v); nl = 4'(nl_v); st = 8'(st_v);
            end else begin
                sel = (i == dup_at) ? 6'($urandom_range(0, 39)) : 6'($urandom_range(0, 63));
                nl  = 4'($urandom_range(0, 15));
                st  = 8'($urandom_range(0, 255));
            end
            abort = (i == abort_at);
            if (i == rst_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                chk("rst_scan", int'(scan), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_selerr", int'(serr), 0);
                chk("rst_count", int'(cnt), 0);
                last_count = 0;
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                repeat (len + 5) @(posedge clk);
                #1;
                return;
            end
            @(posedge clk); #1;
            if (i == abort_at) begin
                abort = 1'b0;
                start = 1'b0;
                @(negedge clk);
                chk("abort_busy", int'(busy), 0);
                chk("abort_count", int'(cnt), last_count);
                repeat (4) @(posedge clk);
                #1;
                return;
            end
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        last_count = exp_cnt;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sv, nv, tv, mv;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_scan", int'(scan), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_selerr", int'(serr), 0);
        chk("reset_count", int'(cnt), 0);

        rst_n = 1'b1;
        // start presented in the very first cycle after release
        run_scan(0, 4, 3, 1, -1, -1, -1);
        run_scan(20, 6, 0, 2, -1, 10, -1);
        run_scan(39, 15, 2, 1, -1, -1, -1);
        run_scan(45, 4, 0, 0, -1, -1, -1);
        run_scan(7, 5, 2, 0, 2 + 2 + 5, 4, -1);
        run_scan(10, 3, 10, 0, -1, -1, 4);
        run_scan(3, 4, 1, 1, -1, -1, -1);
        run_scan(14, 0, 0, 1, -1, -1, -1);

        for (int k = 0; k < 12; k++) begin
            sv = $urandom_range(0, 47);
            nv = $urandom_range(0, 8);
            tv = $urandom_range(0, 20);
            mv = $urandom_range(0, 3);
            run_scan(sv, nv, tv, mv, -1, (k % 3 == 0) ? 3 : -1, -1);
        end

        repeat (5) @(posedge clk);
        chk("pending_scan", scan_q.size(), 0);
        chk("pending_done", done_q.size(), 0);
        chk("pending_selerr", err_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ritc_phase_scan_accumulator.md
RITC_PHASE_SCAN_ACCUMULATOR -- requirements
Module: ritc_phase_scan_accumulator

Interface
REQ-001 Parameter MAX_LOG2, default 12, maximum log2 of the sample count.
REQ-002 Parameter NBITS, default 40, number of scannable bits (3 CLK + 36 CH + 1 VCDL).
REQ-003 user_clk_i  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 user_rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 start_i  in  1  one-cycle scan request.
REQ-006 abort_i  in  1  cancel the scan in progress.
REQ-007 sel_i  in  6  bit select: 0-2 CLK_Q[2:0]; 3-14 CH0_Q[11:0]; 15-26 CH1_Q; 27-38 CH2_Q; 39 VCDL_Q.
REQ-008 nsamp_log2_i  in  4  sample count = 2^n.
REQ-009 settle_i  in  8  settle cycles between scan pulse and first sample.
REQ-010 CLK_Q_i  in  3 / CH0_Q_i, CH1_Q_i, CH2_Q_i  in  12 each / VCDL_Q_i  in  1  resynced phase-scanner samples, already in user_clk_i domain.
REQ-011 scan_o  out  1  one-cycle pulse to the phase-scanner registers' user_scan_i.
REQ-012 busy_o  out  1  high from scan_o cycle through the done_o cycle.
REQ-013 done_o  out  1  one-cycle pulse; count_o valid.
REQ-014 count_o  out  13  number of '1' samples of the selected bit.
REQ-015 sel_err_o  out  1  one-cycle pulse on a rejected start.

Function
REQ-016 FSM states SHALL be IDLE, REQ, SETTLE, ACCUM, DONE.
REQ-017 IDLE with start_i=1 and sel_i<NBITS: latch sel_i, clamped nsamp_log2_i and settle_i; go to REQ.
REQ-018 IDLE with start_i=1 and sel_i>=NBITS: pulse sel_err_o the next cycle; stay in IDLE; count_o unchanged.
REQ-019 nsamp_log2_i > MAX_LOG2 SHALL be clamped to MAX_LOG2.
REQ-020 REQ: scan_o=1 for exactly this cycle; go to SETTLE, or to ACCUM when latched settle=0.
REQ-021 SETTLE: stay exactly latched-settle cycles; then go to ACCUM.
REQ-022 ACCUM: stay exactly 2^n cycles.
REQ-023 ACCUM: each cycle, add the selected input bit (combinational mux of the current inputs) to a 13-bit accumulator.
REQ-024 The accumulator SHALL be cleared on entry to ACCUM.
REQ-025 Accumulator width SHALL be MAX_LOG2+1 bits, so that all-ones at 2^12 yields 4096 without wrap.
REQ-026 DONE: count_o <= accumulator, done_o=1 for one cycle, then go to IDLE.
REQ-027 Latency from the start_i edge to the done_o cycle SHALL be 2 + settle + 2^n cycles; busy_o SHALL be low again the following cycle.
REQ-028 start_i while busy_o=1 SHALL be ignored, with no queuing.
REQ-029 abort_i in any non-IDLE state SHALL go to IDLE next cycle, with no done_o and count_o unchanged.
REQ-030 abort_i SHALL take priority over all other transitions.
REQ-031 start_i and abort_i together in IDLE: start SHALL be accepted; abort has no effect in IDLE.
REQ-032 Input changes during a scan SHALL not affect the latched sel, n or settle.

Reset
REQ-033 user_rst_n_i low SHALL immediately force: state IDLE; scan_o, busy_o, done_o, sel_err_o = 0; count_o = 0; accumulator and counters = 0.
REQ-034 Reset asserted mid-scan SHALL discard the scan; no done_o after release.
REQ-035 The first start_i SHALL be accepted on the first rising edge after reset deassertion.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, the sel range constants (CLK_BASE=0, CH0_BASE=3, CH1_BASE=15, CH2_BASE=27, VCDL_IDX=39) and MAX_LOG2.
REQ-037 One sub-module, ritc_scan_bit_mux, SHALL map the 40 inputs plus sel to a single bit (combinational).
REQ-038 The FSM and counters SHALL reside in the top module.

Verification
REQ-039 sel=0, n=4, settle=3, CLK_Q_i[0]=1 constant, start -> scan_o one cycle later; done_o 21 cycles after start; count_o=16.
REQ-040 sel=20 (CH1 bit 5) toggling every cycle, n=6, settle=0 -> count_o=32; done_o 66 cycles after start.
REQ-041 sel=39, VCDL=1, nsamp_log2_i=15 -> clamped to 12; count_o=4096; busy_o high for 4098+settle cycles.
REQ-042 sel=45, start -> sel_err_o pulse, no scan_o, busy_o stays 0, count_o keeps its prior value.
REQ-043 abort_i in ACCUM cycle 5 -> IDLE next cycle, no done_o; a second start_i during the scan is ignored.
REQ-044 Reset asserted during SETTLE -> all outputs 0 immediately; no done_o after release; a new start then runs normally.
